// File: rtl/char_codes_pkg.sv
// Display character codes shared by the time parser and the time-to-character converter.
// Also holds the parser state encoding.
package char_codes_pkg;

    localparam logic [7:0] CH_COLON = 8'd10;
    localparam logic [7:0] CH_BLANK = 8'd12;
    localparam logic [7:0] CH_PM    = 8'd100;
    localparam logic [7:0] CH_AM    = 8'd115;
    localparam logic [7:0] CH_M     = 8'd112;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_H2     = 3'd1;
    localparam state_t ST_COL    = 3'd2;
    localparam state_t ST_M1     = 3'd3;
    localparam state_t ST_M2     = 3'd4;
    localparam state_t ST_MER    = 3'd5;
    localparam state_t ST_COMMIT = 3'd6;

    function automatic logic is_digit(input logic [7:0] c);
        return c <= 8'd9;
    endfunction

endpackage

// File: rtl/char_time_parser_if.sv
// Character stream handshake between the entry logic (master) and the parser (slave).
interface char_time_parser_if;

    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;

    modport master (output char_in, output char_valid, input char_ready);
    modport slave  (input char_in, input char_valid, output char_ready);

endinterface

// File: rtl/bcd2_to_bin.sv
// Combines a tens digit and a ones digit into an 8-bit binary value.
module bcd2_to_bin (
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [7:0] bin
);

    // tens*10 as tens*8 + tens*2
    assign bin = {1'b0, tens, 3'b000} + {3'b000, tens, 1'b0} + {4'b0000, ones};

endmodule

// File: rtl/char_time_parser.sv
// Parses H1 H2 ':' M1 M2 AM/PM character codes and commits a binary 12-hour time.
// A blank in IDLE commits the NIL time; a blank mid-entry silently abandons the entry.
module char_time_parser
    import char_codes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 32
) (
    input  logic               clock,
    input  logic               reset,
    char_time_parser_if.slave  chr,
    output logic [7:0]         hour,
    output logic [7:0]         minute,
    output logic               ampm,
    output logic               time_valid,
    output logic               error,
    output logic               busy
);

    localparam bit               TO_EN   = TIMEOUT_CYCLES > 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic [3:0]       h1_q, h1_d, h2_q, h2_d, m1_q, m1_d, m2_q, m2_d;
    logic [7:0]       hour_q, hour_d, minute_q, minute_d;
    logic             ampm_q, ampm_d;
    logic             err_q, bad;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       hour_bin, minute_bin;
    logic [7:0]       c;
    logic             fire, mid, h2_ok;

    bcd2_to_bin u_hour_bin (
        .tens (h1_q),
        .ones (h2_q),
        .bin  (hour_bin)
    );

    bcd2_to_bin u_minute_bin (
        .tens (m1_q),
        .ones (m2_q),
        .bin  (minute_bin)
    );

    assign c              = chr.char_in;
    assign chr.char_ready = (state_q != ST_COMMIT);
    assign fire           = chr.char_valid && chr.char_ready;
    assign mid            = (state_q != ST_IDLE) && (state_q != ST_COMMIT);
    assign h2_ok          = ((h1_q == 4'd0) && (c >= 8'd1) && is_digit(c)) ||
                            ((h1_q == 4'd1) && (c <= 8'd2));

    always_comb begin
        state_d  = state_q;
        h1_d     = h1_q;
        h2_d     = h2_q;
        m1_d     = m1_q;
        m2_d     = m2_q;
        hour_d   = hour_q;
        minute_d = minute_q;
        ampm_d   = ampm_q;
        cnt_d    = '0;
        bad      = 1'b0;
        if (fire) begin
            case (state_q)
                ST_IDLE: begin
                    if (c <= 8'd1) begin
                        h1_d    = c[3:0];
                        state_d = ST_H2;
                    end else if (c == CH_BLANK) begin
                        hour_d   = '0;
                        minute_d = '0;
                        ampm_d   = 1'b0;
                        state_d  = ST_COMMIT;
                    end else begin
                        bad = 1'b1;
                    end
                end
                ST_H2: begin
                    if (c == CH_BLANK) state_d = ST_IDLE;
                    else if (h2_ok) begin
                        h2_d    = c[3:0];
                        state_d = ST_COL;
                    end else bad = 1'b1;
                end
                ST_COL: begin
                    if (c == CH_BLANK) state_d = ST_IDLE;
                    else if (c == CH_COLON) state_d = ST_M1;
                    else bad = 1'b1;
                end
                ST_M1: begin
                    if (c == CH_BLANK) state_d = ST_IDLE;
                    else if (c <= 8'd5) begin
                        m1_d    = c[3:0];
                        state_d = ST_M2;
                    end else bad = 1'b1;
                end
                ST_M2: begin
                    if (c == CH_BLANK) state_d = ST_IDLE;
                    else if (is_digit(c)) begin
                        m2_d    = c[3:0];
                        state_d = ST_MER;
                    end else bad = 1'b1;
                end
                ST_MER: begin
                    if (c == CH_BLANK) state_d = ST_IDLE;
                    else if ((c == CH_PM) || (c == CH_AM)) begin
                        hour_d   = hour_bin;
                        minute_d = minute_bin;
                        ampm_d   = (c == CH_PM);
                        state_d  = ST_COMMIT;
                    end else bad = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (mid) begin
            // An accepted char on the timeout edge takes the fire branch, so it wins
            if (TO_EN && (cnt_q == TO_LAST)) bad = 1'b1;
            else cnt_d = cnt_q + 1'b1;
        end else if (state_q == ST_COMMIT) begin
            state_d = ST_IDLE;
        end
        if (bad) state_d = ST_IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            h1_q     <= '0;
            h2_q     <= '0;
            m1_q     <= '0;
            m2_q     <= '0;
            hour_q   <= '0;
            minute_q <= '0;
            ampm_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            h1_q     <= h1_d;
            h2_q     <= h2_d;
            m1_q     <= m1_d;
            m2_q     <= m2_d;
            hour_q   <= hour_d;
            minute_q <= minute_d;
            ampm_q   <= ampm_d;
            err_q    <= bad;
            cnt_q    <= cnt_d;
        end
    end

    assign hour       = hour_q;
    assign minute     = minute_q;
    assign ampm       = ampm_q;
    assign error      = err_q;
    assign time_valid = (state_q == ST_COMMIT);
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_char_time_parser.sv
// Directed vector bench for char_time_parser, built with a 4-cycle entry timeout.
module tb_char_time_parser;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] hour, minute;
    logic       ampm, time_valid, error, busy;
    int         checks = 0;
    int         failures = 0;

    char_time_parser_if cif ();

    char_time_parser #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .chr        (cif),
        .hour       (hour),
        .minute     (minute),
        .ampm       (ampm),
        .time_valid (time_valid),
        .error      (error),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int              n;
        logic [5:0][7:0] ch;
        logic            err;
        logic            tv;
        int              hr;
        int              mn;
        logic            ap;
        logic            bz;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(int n, logic [7:0] c0, logic [7:0] c1, logic [7:0] c2,
                                logic [7:0] c3, logic [7:0] c4, logic [7:0] c5, logic e,
                                logic tv, int hr, int mn, logic ap, logic bz);
        vec_t v;
        v.n = n;
        v.ch[0] = c0; v.ch[1] = c1; v.ch[2] = c2;
        v.ch[3] = c3; v.ch[4] = c4; v.ch[5] = c5;
        v.err = e; v.tv = tv; v.hr = hr; v.mn = mn; v.ap = ap; v.bz = bz;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] c);
        cif.char_valid = 1'b1;
        cif.char_in    = c;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cif.char_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input int hr, input int mn, input logic ap);
        chk({tag, " hour"}, int'(hour), hr);
        chk({tag, " minute"}, int'(minute), mn);
        chk({tag, " ampm"}, int'(ampm), int'(ap));
    endtask

    initial begin
        cif.char_valid = 1'b0;
        cif.char_in    = 8'd0;

        vecs[0]  = mk(6, 0, 7, 10, 0, 5, 115, 0, 1, 7, 5, 0, 1);
        vecs[1]  = mk(6, 1, 2, 10, 4, 5, 100, 0, 1, 12, 45, 1, 1);
        vecs[2]  = mk(2, 1, 3, 0, 0, 0, 0, 1, 0, 12, 45, 1, 0);
        vecs[3]  = mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 12, 45, 1, 0);
        vecs[4]  = mk(4, 0, 9, 10, 6, 0, 0, 1, 0, 12, 45, 1, 0);
        vecs[5]  = mk(6, 0, 9, 10, 5, 9, 112, 1, 0, 12, 45, 1, 0);
        vecs[6]  = mk(3, 1, 0, 5, 0, 0, 0, 1, 0, 12, 45, 1, 0);
        vecs[7]  = mk(1, 12, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        vecs[8]  = mk(3, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(1, 99, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        vecs[10] = mk(6, 1, 0, 10, 5, 9, 115, 0, 1, 10, 59, 0, 1);
        vecs[11] = mk(6, 0, 1, 10, 0, 0, 100, 0, 1, 1, 0, 1, 1);
        vecs[12] = mk(5, 0, 9, 10, 3, 12, 0, 0, 0, 1, 0, 1, 0);
        vecs[13] = mk(6, 1, 2, 10, 3, 0, 12, 0, 0, 1, 0, 1, 0);

        // Reset state
        #2;
        chk_out("reset", 0, 0, 0);
        chk("reset time_valid", int'(time_valid), 0);
        chk("reset error", int'(error), 0);
        chk("reset ready", int'(cif.char_ready), 1);
        chk("reset busy", int'(busy), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle();

        for (int v = 0; v < 14; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            for (int i = 0; i < vecs[v].n; i++) begin
                drive(vecs[v].ch[i]);
                if (i < vecs[v].n - 1)
                    chk($sformatf("%s char%0d error", tag, i), int'(error), 0);
            end
            chk({tag, " error"}, int'(error), int'(vecs[v].err));
            chk({tag, " time_valid"}, int'(time_valid), int'(vecs[v].tv));
            chk({tag, " ready"}, int'(cif.char_ready), int'(!vecs[v].tv));
            chk({tag, " busy"}, int'(busy), int'(vecs[v].bz));
            chk_out(tag, vecs[v].hr, vecs[v].mn, vecs[v].ap);
            idle();
            chk({tag, " pulse end tv"}, int'(time_valid), 0);
            chk({tag, " pulse end err"}, int'(error), 0);
            chk({tag, " idle busy"}, int'(busy), 0);
            idle();
        end

        // Timeout: four transfer-free cycles after H1 abort with error
        drive(8'd1);
        idle(); idle(); idle();
        chk("timeout early error", int'(error), 0);
        chk("timeout early busy", int'(busy), 1);
        idle();
        chk("timeout error", int'(error), 1);
        chk("timeout busy", int'(busy), 0);
        chk_out("timeout", 1, 0, 1);
        idle();
        chk("timeout pulse end", int'(error), 0);

        // A char on the timeout edge wins
        drive(8'd1);
        idle(); idle(); idle();
        drive(8'd0);
        chk("race error", int'(error), 0);
        chk("race busy", int'(busy), 1);
        drive(8'd10); drive(8'd3); drive(8'd0); drive(8'd115);
        chk("race time_valid", int'(time_valid), 1);
        chk_out("race", 10, 30, 0);
        idle(); idle();

        // Held valid with repeated blank: COMMIT blocks the second transfer for one cycle
        drive(8'd12);
        chk("held tv0", int'(time_valid), 1);
        chk_out("held", 0, 0, 0);
        @(posedge clock);
        #1;
        chk("held tv1", int'(time_valid), 0);
        chk("held ready1", int'(cif.char_ready), 1);
        @(posedge clock);
        #1;
        chk("held tv2", int'(time_valid), 1);
        idle(); idle();

        // Give the outputs a non-NIL value, then reset mid-entry
        drive(8'd0); drive(8'd8); drive(8'd10); drive(8'd2); drive(8'd7); drive(8'd100);
        chk_out("pre-reset", 8, 27, 1);
        idle();
        drive(8'd1); drive(8'd0); drive(8'd10);
        cif.char_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_out("async reset", 0, 0, 0);
        chk("async reset busy", int'(busy), 0);
        chk("async reset ready", int'(cif.char_ready), 1);
        chk("async reset tv", int'(time_valid), 0);
        chk("async reset err", int'(error), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle();
        drive(8'd1); drive(8'd1); drive(8'd10); drive(8'd1); drive(8'd1); drive(8'd100);
        chk("post-reset time_valid", int'(time_valid), 1);
        chk("post-reset error", int'(error), 0);
        chk_out("post-reset", 11, 11, 1);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
